wave_config: RTL and testbench
==============================

# wave_config

Register-write slave on the MCU parallel bus: the MCU writes divider, gain and period settings into shadow registers, then requests an apply, and the block transfers the shadow set to its active outputs. When the waveform engine is running, the transfer waits for a frame boundary, so the settings never change mid-frame. It sits beside the register-readout slave on the same bus strobes, feeding the clock divider, gain stage and period counter.

## Interface
- DATA_WIDTH, 16, bus data width
- DIV_WIDTH, 12, divider width (division range 0–4095)
- COUNTER_WIDTH, 18, period width; must be ≤ 2*DATA_WIDTH and > DATA_WIDTH
- TIMEOUT, 1048576, cycles to wait in PENDING before the apply is forced
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  block enable; when low, bus strobes are ignored
- addr_en  in  1  latch rd_data as the register address
- rd_en  in  1  write strobe: rd_data is written to the addressed register
- wr_en  in  1  readback strobe (used only with the macro)
- rd_data  in  DATA_WIDTH  bus data from the MCU
- wr_data  out  DATA_WIDTH  readback data
- frame_done  in  1  one-cycle pulse at each waveform frame boundary
- div_out  out  DIV_WIDTH  active divider
- gain_ctrl_out  out  2  active gain control
- period_out  out  COUNTER_WIDTH  active period
- run  out  1  run enable (CTRL bit0; not shadowed, takes effect immediately)
- cfg_update  out  1  one-cycle pulse when the active set is loaded
- busy  out  1  high while in PENDING or APPLY
- timeout_flag  out  1  sticky flag: an apply was forced by timeout

## Operation
Register address map:
- 0 = DIV: shadow_div ← rd_data[DIV_WIDTH-1:0].
- 1 = GAIN: shadow_gain ← rd_data[1:0].
- 2 = PERIOD_LOW: the value goes to a staging register only.
- 3 = PERIOD_HIGH: shadow_period ← {rd_data[COUNTER_WIDTH-DATA_WIDTH-1:0], staging}, in one write; the unused upper bits are ignored.
- 4 = CTRL:
  - bit0 → run.
  - bit1 = apply request.
  - bit2 = write 1 to clear timeout_flag.
- 5 = STATUS: read-only; {busy, timeout_flag, run} in bits [2:0].
- Other addresses: writes are ignored.

Bus behaviour:
- addr_en latches the address on the clock edge.
- A write on rd_en uses the address latched before that edge. When addr_en and rd_en are high in the same cycle, the write goes to the old address.

Apply state machine (IDLE, PENDING, APPLY):
- IDLE → PENDING on an apply request when run = 1; the timeout counter is cleared.
- IDLE → APPLY on an apply request when run = 0.
- PENDING → APPLY on frame_done, or when the timeout counter reaches TIMEOUT−1. A timeout also sets timeout_flag.
- PENDING → IDLE if run is cleared; in that case the apply happens immediately through APPLY.
- APPLY: the active outputs load the shadow values, cfg_update = 1, then the machine returns to IDLE.
- An apply request during PENDING or APPLY is ignored; it does not queue.
- Shadow writes during PENDING are allowed. APPLY captures the shadow values present in the APPLY cycle.

## Timing
- Reset values:
  - div_out = 1; gain_ctrl_out, period_out and run = 0; cfg_update, busy, timeout_flag and wr_data = 0.
  - All shadow, staging and address registers = 0, except shadow_div = 1.
  - State = IDLE.
- Reset in PENDING aborts the apply; the active outputs return to their reset values.
- Apply with run = 0:
  - CTRL write at edge N → state APPLY after edge N.
  - Outputs and cfg_update change at edge N+1.
- Apply with run = 1:
  - frame_done is sampled only while in PENDING.
  - A frame_done coincident with the CTRL write edge is not counted.
  - frame_done sampled at edge M → outputs change at edge M+1.
- busy is asserted from the edge after the request until the edge after APPLY.
- When timeout and frame_done occur in the same cycle, frame_done takes priority and timeout_flag is not set.

## Configuration
- WAVE_CONFIG_READBACK_EN defined:
  - On wr_en, wr_data ← the value at the latched address.
  - Addresses 0–3 return the active values, zero-extended; address 3 returns period_out's upper bits.
  - Address 4 returns {1'b0, run}; address 5 returns STATUS.
  - Unmapped addresses return 16'hFFFF.
  - wr_data holds its value between strobes.
- Not defined: wr_data is constant 0 and wr_en is ignored.

## Structure
- The package wave_cfg_pkg holds:
  - the address localparams (DIV_ADDR … STATUS_ADDR);
  - the CTRL bit indices;
  - the state enum typedef (IDLE, PENDING, APPLY);
  - a struct typedef for the shadow/active register set.
- One sub-module, wave_cfg_apply_fsm: the state machine plus the timeout counter, with the inputs req, run, frame_done and the outputs load, busy, timeout_set.

## Test plan
- Write DIV = 0x0064 with run = 0, then CTRL = 0x2 → div_out = 100 at edge N+1, with a single cfg_update pulse.
- Write LOW = 0xABCD, then HIGH = 0xFFFF, then apply → period_out = 18'h3ABCD; writing LOW alone leaves period_out unchanged.
- Set run = 1, write GAIN = 2, apply → busy high and gain_ctrl_out held at 0 until frame_done; it becomes 2 one edge after frame_done.
- Set TIMEOUT = 16, run = 1, apply with no frame_done → forced apply after 16 cycles and timeout_flag = 1; a CTRL write with bit2 clears the flag.
- Assert addr_en(5) and rd_en in the same cycle, with the prior address 1 → the write lands in GAIN; with the macro, reading address 5 returns the status bits.
- Assert rst in PENDING → outputs at reset values, busy = 0, and no cfg_update pulse.

Source files
------------

// File: rtl/wave_cfg_pkg.sv
// Shared definitions for the wave_config register slave:
// register map, CTRL bit positions, apply states and register-set bundle.
package wave_cfg_pkg;

    localparam int DIV_W    = 12;
    localparam int PERIOD_W = 18;

    localparam logic [15:0] DIV_ADDR    = 16'd0;
    localparam logic [15:0] GAIN_ADDR   = 16'd1;
    localparam logic [15:0] PLOW_ADDR   = 16'd2;
    localparam logic [15:0] PHIGH_ADDR  = 16'd3;
    localparam logic [15:0] CTRL_ADDR   = 16'd4;
    localparam logic [15:0] STATUS_ADDR = 16'd5;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_APPLY = 1;
    localparam int CTRL_CLR   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } apply_state_t;

    typedef struct packed {
        logic [DIV_W-1:0]    div;
        logic [1:0]          gain;
        logic [PERIOD_W-1:0] period;
    } wave_regs_t;

endpackage

// File: rtl/wave_cfg_apply_fsm.sv
// Apply sequencer: defers a shadow->active transfer to a frame boundary
// while the engine runs, with a timeout that forces the transfer.
module wave_cfg_apply_fsm
    import wave_cfg_pkg::*;
#(
    parameter int TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic run,
    input  logic frame_done,
    output logic load,
    output logic busy,
    output logic timeout_set
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    apply_state_t     r_state;
    apply_state_t     w_next;
    logic [CNT_W-1:0] r_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Timeout counter: held at zero outside PENDING so it restarts on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_cnt <= '0;
        else if (r_state == PENDING) r_cnt <= r_cnt + 1'b1;
        else                         r_cnt <= '0;
    end

    // Next-state and outputs; frame_done outranks the timeout
    always_comb begin
        w_next      = r_state;
        load        = 1'b0;
        timeout_set = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (req) w_next = run ? PENDING : APPLY;
            end
            PENDING: begin
                if (frame_done) begin
                    w_next = APPLY;
                end else if (r_cnt == LAST) begin
                    w_next      = APPLY;
                    timeout_set = 1'b1;
                end else if (!run) begin
                    w_next = APPLY;
                end
            end
            APPLY: begin
                load   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: rtl/wave_config.sv
// MCU-bus register slave holding shadow/active waveform settings.
// Optional readback path: define WAVE_CONFIG_READBACK_EN.
module wave_config
    import wave_cfg_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int DIV_WIDTH     = DIV_W,
    parameter int COUNTER_WIDTH = PERIOD_W,
    parameter int TIMEOUT       = 1048576
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     addr_en,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     frame_done,
    output logic [DIV_WIDTH-1:0]     div_out,
    output logic [1:0]               gain_ctrl_out,
    output logic [COUNTER_WIDTH-1:0] period_out,
    output logic                     run,
    output logic                     cfg_update,
    output logic                     busy,
    output logic                     timeout_flag
);

    localparam int HI_W = COUNTER_WIDTH - DATA_WIDTH;

    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_staging;
    wave_regs_t            r_shadow;
    wave_regs_t            r_active;
    logic                  r_run;
    logic                  r_tflag;
    logic                  r_cfg_update;

    logic w_wr;
    logic w_ctrl_wr;
    logic w_run_nxt;
    logic w_req;
    logic w_load;
    logic w_busy;
    logic w_tset;

    assign w_wr      = en && rd_en;
    assign w_ctrl_wr = w_wr && (r_addr == CTRL_ADDR);
    assign w_run_nxt = w_ctrl_wr ? rd_data[CTRL_RUN] : r_run;
    assign w_req     = w_ctrl_wr && rd_data[CTRL_APPLY];

    wave_cfg_apply_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .req         (w_req),
        .run         (w_run_nxt),
        .frame_done  (frame_done),
        .load        (w_load),
        .busy        (w_busy),
        .timeout_set (w_tset)
    );

    // Address latch; a same-cycle write still sees the old address
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_addr <= '0;
        else if (en && addr_en) r_addr <= rd_data;
    end

    // Shadow register writes from the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow.div    <= DIV_WIDTH'(1);
            r_shadow.gain   <= 2'd0;
            r_shadow.period <= '0;
            r_staging       <= '0;
        end else if (w_wr) begin
            case (r_addr)
                DIV_ADDR:   r_shadow.div    <= rd_data[DIV_WIDTH-1:0];
                GAIN_ADDR:  r_shadow.gain   <= rd_data[1:0];
                PLOW_ADDR:  r_staging       <= rd_data;
                PHIGH_ADDR: r_shadow.period <= {rd_data[HI_W-1:0], r_staging};
                default:    ;
            endcase
        end
    end

    // Run enable and sticky timeout flag; a new timeout beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_tflag <= 1'b0;
        end else begin
            r_run <= w_run_nxt;
            if (w_tset)
                r_tflag <= 1'b1;
            else if (w_ctrl_wr && rd_data[CTRL_CLR])
                r_tflag <= 1'b0;
        end
    end

    // Active set loads from shadow in the APPLY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active.div    <= DIV_WIDTH'(1);
            r_active.gain   <= 2'd0;
            r_active.period <= '0;
            r_cfg_update    <= 1'b0;
        end else begin
            r_cfg_update <= w_load;
            if (w_load) r_active <= r_shadow;
        end
    end

`ifdef WAVE_CONFIG_READBACK_EN
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] w_rb;

    // Readback value selected by the latched address
    always_comb begin
        w_rb = '1;
        case (r_addr)
            DIV_ADDR:    w_rb = DATA_WIDTH'(r_active.div);
            GAIN_ADDR:   w_rb = DATA_WIDTH'(r_active.gain);
            PLOW_ADDR:   w_rb = r_active.period[DATA_WIDTH-1:0];
            PHIGH_ADDR:  w_rb = DATA_WIDTH'(r_active.period[COUNTER_WIDTH-1:DATA_WIDTH]);
            CTRL_ADDR:   w_rb = DATA_WIDTH'(r_run);
            STATUS_ADDR: w_rb = DATA_WIDTH'({w_busy, r_tflag, r_run});
            default:     w_rb = '1;
        endcase
    end

    // Readback register holds between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_wr_data <= '0;
        else if (en && wr_en) r_wr_data <= w_rb;
    end

    assign wr_data = r_wr_data;
`else
    logic w_unused_wr_en;
    assign w_unused_wr_en = wr_en;
    assign wr_data        = '0;
`endif

    assign div_out       = r_active.div;
    assign gain_ctrl_out = r_active.gain;
    assign period_out    = r_active.period;
    assign run           = r_run;
    assign cfg_update    = r_cfg_update;
    assign busy          = w_busy;
    assign timeout_flag  = r_tflag;

endmodule

// File: tb/tb_wave_config.sv
// Directed bench for wave_config (TIMEOUT shortened to 16).
// Readback checks compile in when WAVE_CONFIG_READBACK_EN is defined.
module tb_wave_config;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        addr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] rd_data = '0;
    logic [15:0] wr_data;
    logic        frame_done = 1'b0;
    logic [11:0] div_out;
    logic [1:0]  gain_ctrl_out;
    logic [17:0] period_out;
    logic        run;
    logic        cfg_update;
    logic        busy;
    logic        timeout_flag;

    int checks = 0;
    int failures = 0;

    wave_config #(
        .DATA_WIDTH    (16),
        .DIV_WIDTH     (12),
        .COUNTER_WIDTH (18),
        .TIMEOUT       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .addr_en       (addr_en),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .rd_data       (rd_data),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .div_out       (div_out),
        .gain_ctrl_out (gain_ctrl_out),
        .period_out    (period_out),
        .run           (run),
        .cfg_update    (cfg_update),
        .busy          (busy),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge just after the write edge
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr_en = 1'b1;
        rd_data = a;
        @(negedge clk);
        addr_en = 1'b0;
        rd_en   = 1'b1;
        rd_data = d;
        @(negedge clk);
        rd_en   = 1'b0;
    endtask

    task automatic rb(input logic [15:0] a);
        @(negedge clk);
        addr_en = 1'b1;
        rd_data = a;
        @(negedge clk);
        addr_en = 1'b0;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_div", div_out, 1);
        chk("rst_gain", gain_ctrl_out, 0);
        chk("rst_period", period_out, 0);
        chk("rst_run", run, 0);
        chk("rst_upd", cfg_update, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tflag", timeout_flag, 0);
        chk("rst_wrdata", wr_data, 0);

        // Immediate apply with run = 0
        wr(16'd0, 16'h0064);
        wr(16'd4, 16'h0002);
        chk("a0_div_hold", div_out, 1);
        chk("a0_busy", busy, 1);
        chk("a0_upd_early", cfg_update, 0);
        @(negedge clk);
        chk("a0_div", div_out, 100);
        chk("a0_upd", cfg_update, 1);
        chk("a0_busy_off", busy, 0);
        @(negedge clk);
        chk("a0_upd_single", cfg_update, 0);

        // Period staging: LOW alone does not reach the shadow
        wr(16'd2, 16'hABCD);
        wr(16'd4, 16'h0002);
        @(negedge clk);
        chk("plow_upd", cfg_update, 1);
        chk("plow_only", period_out, 0);
        wr(16'd3, 16'hFFFF);
        wr(16'd4, 16'h0002);
        @(negedge clk);
        chk("period", period_out, 18'h3ABCD);

        // Frame-synchronised apply
        wr(16'd4, 16'h0001);
        chk("run_set", run, 1);
        wr(16'd1, 16'h0002);
        wr(16'd4, 16'h0003);
        chk("pend_busy", busy, 1);
        chk("pend_gain", gain_ctrl_out, 0);
        repeat (3) @(negedge clk);
        chk("pend_busy2", busy, 1);
        chk("pend_gain2", gain_ctrl_out, 0);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        chk("fd_gain_hold", gain_ctrl_out, 0);
        @(negedge clk);
        chk("fd_gain", gain_ctrl_out, 2);
        chk("fd_upd", cfg_update, 1);
        chk("fd_busy_off", busy, 0);

        // Timeout; frame_done on the request edge must not count
        wr(16'd0, 16'h0200);
        @(negedge clk);
        addr_en = 1'b1;
        rd_data = 16'd4;
        @(negedge clk);
        addr_en    = 1'b0;
        rd_en      = 1'b1;
        rd_data    = 16'h0003;
        frame_done = 1'b1;
        @(negedge clk);
        rd_en      = 1'b0;
        frame_done = 1'b0;
        repeat (15) @(negedge clk);
        chk("to_busy", busy, 1);
        chk("to_div_hold", div_out, 100);
        chk("to_flag_early", timeout_flag, 0);
        @(negedge clk);
        chk("to_flag", timeout_flag, 1);
        chk("to_div_hold2", div_out, 100);
        @(negedge clk);
        chk("to_div", div_out, 12'h200);
        chk("to_upd", cfg_update, 1);
`ifdef WAVE_CONFIG_READBACK_EN
        rb(16'd5);
        chk("rb_status", wr_data, 16'h0003);
`endif
        wr(16'd4, 16'h0005);
        chk("to_clear", timeout_flag, 0);
        chk("to_run_kept", run, 1);

        // Same-cycle addr_en/rd_en writes to the old address (GAIN)
        wr(16'd4, 16'h0000);
        wr(16'd1, 16'h0003);
        @(negedge clk);
        addr_en = 1'b1;
        rd_en   = 1'b1;
        rd_data = 16'd5;
        @(negedge clk);
        addr_en = 1'b0;
        rd_en   = 1'b0;
`ifdef WAVE_CONFIG_READBACK_EN
        @(negedge clk);
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("rb_status0", wr_data, 16'h0000);
        rb(16'd7);
        chk("rb_unmapped", wr_data, 16'hFFFF);
`else
        rb(16'd1);
        chk("rb_off", wr_data, 0);
`endif
        wr(16'd4, 16'h0002);
        @(negedge clk);
        chk("same_cyc_gain", gain_ctrl_out, 1);

        // Clearing run while pending applies at once
        wr(16'd4, 16'h0001);
        wr(16'd1, 16'h0000);
        wr(16'd4, 16'h0003);
        wr(16'd4, 16'h0000);
        chk("runclr_busy", busy, 1);
        @(negedge clk);
        chk("runclr_gain", gain_ctrl_out, 0);
        chk("runclr_upd", cfg_update, 1);

        // Reset while pending
        wr(16'd4, 16'h0001);
        wr(16'd0, 16'h0007);
        wr(16'd4, 16'h0003);
        chk("rp_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rp_div", div_out, 1);
        chk("rp_period", period_out, 0);
        chk("rp_busy_off", busy, 0);
        chk("rp_run", run, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rp_no_upd", cfg_update, 0);
        end
        chk("rp_div_after", div_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
